// File: rtl/tx_interface_if.sv
// Result/UART-TX handshake bundle for tx_interface.
// master drives the result request and tx_done_tick; slave is the formatter.
interface tx_interface_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              tx_done_tick;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              busy;
  logic              done_tick;

  modport master (
    output result,
    output result_valid,
    output tx_done_tick,
    input  tx_data,
    input  tx_start,
    input  busy,
    input  done_tick
  );

  modport slave (
    input  result,
    input  result_valid,
    input  tx_done_tick,
    output tx_data,
    output tx_start,
    output busy,
    output done_tick
  );
endinterface

// File: rtl/tx_interface.sv
// Latches an ALU result and streams it to UART TX as lowercase ASCII hex.
// Define TX_CRLF_EN to append CR LF after the hex digits.
module tx_interface #(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  tx_interface_if.slave bus
);

  localparam int NDIG = DATA_W / 4;
`ifdef TX_CRLF_EN
  localparam int LAST = NDIG + 1;
`else
  localparam int LAST = NDIG - 1;
`endif
  localparam int CNT_W = $clog2(LAST + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [3:0]        nib;
  logic [7:0]        ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Character for the current digit index, MSB nibble first.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CNT_W'(i))
        nib = shadow_q[DATA_W-1-4*i -: 4];
    end
    if (nib < 4'd10)
      ch = 8'h30 + {4'h0, nib};
    else
      ch = 8'h57 + {4'h0, nib};
`ifdef TX_CRLF_EN
    if (cnt_q == CNT_W'(NDIG))
      ch = 8'h0D;
    if (cnt_q == CNT_W'(NDIG + 1))
      ch = 8'h0A;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.result_valid) begin
          shadow_d = bus.result;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done_tick) begin
          if (cnt_q == CNT_W'(LAST)) begin
            state_d = S_FINISH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_START;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_start  = (state_q == S_START);
    bus.busy      = (state_q != S_IDLE);
    bus.done_tick = (state_q == S_FINISH);
    bus.tx_data   = '0;
    if (state_q == S_START || state_q == S_WAIT)
      bus.tx_data = ch;
  end

endmodule

// File: tb/tb_tx_interface.sv
// Directed bench for tx_interface: hex formatting, busy window,
// ignored requests/ticks and mid-sequence reset.
module tb_tx_interface;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tx_interface_if #(.DATA_W(8)) bus ();

  tx_interface #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v,
                      input logic [7:0] c0,
                      input logic [7:0] c1,
                      input bit disturb,
                      input bit tick_idle);
    logic [7:0] exp[$];
    int last;
    exp = {c0, c1};
`ifdef TX_CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    last = exp.size() - 1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    bus.result       = v;
    bus.result_valid = 1'b1;
    bus.tx_done_tick = tick_idle;
    @(negedge clk);
    bus.result_valid = 1'b0;
    bus.tx_done_tick = tick_idle;
    for (int k = 0; k <= last; k++) begin
      chk("tx_start", bus.tx_start, 1);
      chk("tx_data", bus.tx_data, exp[k]);
      chk("busy", bus.busy, 1);
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        bus.result_valid = 1'b0;
        chk("start_pulse", bus.tx_start, 0);
        if (w == 9)
          chk("hold_data", bus.tx_data, exp[k]);
        if (disturb && k == 0 && w == 3) begin
          bus.result       = 8'h11;
          bus.result_valid = 1'b1;
        end
      end
      bus.tx_done_tick = 1'b1;
      if (disturb && k == last)
        bus.result_valid = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      bus.result_valid = 1'b0;
    end
    chk("done_tick", bus.done_tick, 1);
    chk("busy_finish", bus.busy, 1);
    chk("finish_start", bus.tx_start, 0);
    if (disturb)
      bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    chk("done_pulse", bus.done_tick, 0);
    chk("busy_end", bus.busy, 0);
    @(negedge clk);
    chk("no_queue_start", bus.tx_start, 0);
    chk("no_queue_busy", bus.busy, 0);
  endtask

  initial begin
    reset            = 1'b0;
    bus.result       = '0;
    bus.result_valid = 1'b0;
    bus.tx_done_tick = 1'b0;
    #1;
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_done", bus.done_tick, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    send(8'h5F, 8'h35, 8'h66, 1'b0, 1'b0);
    send(8'hA0, 8'h61, 8'h30, 1'b0, 1'b0);
    send(8'hFF, 8'h66, 8'h66, 1'b0, 1'b0);
    send(8'h03, 8'h30, 8'h33, 1'b0, 1'b0);
    send(8'h9B, 8'h39, 8'h62, 1'b1, 1'b0);

    @(negedge clk);
    bus.result       = 8'h77;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    chk("abort_start", bus.tx_start, 1);
    chk("abort_char", bus.tx_data, 8'h37);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_tx_start", bus.tx_start, 0);
    chk("abort_tx_data", bus.tx_data, 0);
    chk("abort_done", bus.done_tick, 0);
    @(negedge clk);
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", bus.done_tick, 0);
    end
    reset = 1'b1;
    send(8'h2C, 8'h32, 8'h63, 1'b0, 1'b0);

    @(negedge clk);
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    chk("spur_start", bus.tx_start, 0);
    chk("spur_busy", bus.busy, 0);
    @(negedge clk);
    chk("spur_start2", bus.tx_start, 0);
    chk("spur_busy2", bus.busy, 0);

    send(8'hE4, 8'h65, 8'h34, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
